// File: rtl/secuenciador_mult16_if.sv
// Request/response bundle for the sequential 16x16 multiplier: start/a/b in, busy/done/p out.
interface secuenciador_mult16_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/secuenciador_mult16.sv
// 16x16 unsigned multiplier built from one shared 8x8 byte multiplier.
// Four partial products are shifted and accumulated over four cycles.
module MultiplicadorByte (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] z
);
    assign z = {8'd0, x} * {8'd0, y};
endmodule

module secuenciador_mult16 (
    input  logic                 clk,
    input  logic                 rst_n,
    secuenciador_mult16_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] ra, rb;
    logic [31:0] acc;
    logic [7:0]  mx, my;
    logic [15:0] prod;
    logic [31:0] addend;
    logic        accept;
    logic        acc_en;

    MultiplicadorByte u_mul (
        .x (mx),
        .y (my),
        .z (prod)
    );

    // Operand bytes and the shift of the partial product are decoded from state alone.
    always_comb begin
        state_nxt = state;
        mx        = 8'd0;
        my        = 8'd0;
        addend    = 32'd0;
        accept    = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = P0;
                end
            end
            P0: begin
                mx        = ra[7:0];
                my        = rb[7:0];
                addend    = {16'd0, prod};
                acc_en    = 1'b1;
                state_nxt = P1;
            end
            P1: begin
                mx        = ra[15:8];
                my        = rb[7:0];
                addend    = {8'd0, prod, 8'd0};
                acc_en    = 1'b1;
                state_nxt = P2;
            end
            P2: begin
                mx        = ra[7:0];
                my        = rb[15:8];
                addend    = {8'd0, prod, 8'd0};
                acc_en    = 1'b1;
                state_nxt = P3;
            end
            P3: begin
                mx        = ra[15:8];
                my        = rb[15:8];
                addend    = {prod, 16'd0};
                acc_en    = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Partial sums never exceed 0xFFFE0001, so the 32-bit add cannot carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra  <= 16'd0;
            rb  <= 16'd0;
            acc <= 32'd0;
        end else if (accept) begin
            ra  <= bus.a;
            rb  <= bus.b;
            acc <= 32'd0;
        end else if (acc_en) begin
            acc <= acc + addend;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.p    = acc;
endmodule
